seq_gen_sr: RTL and testbench
=============================

Name: seq_gen_sr

Overview:
- Serial pattern transmitter: the source side of the serial sequence-detection interface.
- Loads a SEQ_LEN-bit pattern on a start handshake and drives it MSB-first, one bit per clk, onto seq_out.
- Supports programmable back-to-back repetitions and an optional idle gap between frames.
- Drives the seq_in stimulus of the downstream shift-register detector in system and bench use.

Parameters:
- SEQ_LEN, 7, pattern width in bits (legal range 2..16).
- SEQ_DEFAULT, 7'b1011010, pattern used when use_default=1.
- GAP_CYCLES, 0, idle-bit cycles inserted between repetitions (0..15).
- IDLE_BIT, 1'b0, value driven on seq_out when no frame bit is being sent.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to send; sampled only when ready=1.
- use_default  input  1  when 1, load SEQ_DEFAULT instead of pattern_in.
- pattern_in  input  SEQ_LEN  pattern, MSB transmitted first.
- reps  input  4  extra repetitions; total frames sent = reps+1 (1..16).
- abort  input  1  synchronous cancel of the current transfer.
- ready  output  1  high in IDLE; start is accepted.
- seq_out  output  1  serial data bit, registered.
- seq_valid  output  1  high while seq_out carries a pattern bit; low in gap and idle.
- frame_last  output  1  high with the last bit of every frame.
- done  output  1  one-cycle pulse with the last bit of the final frame.

Behaviour:
- Reset values (async, while rst_n=0):
  - state=IDLE, ready=1, seq_out=IDLE_BIT, seq_valid=0, frame_last=0, done=0.
  - Bit counter, frame counter, gap counter and shift register all cleared.
- Reset mid-transfer: output returns to idle immediately and no done is produced.
- FSM has three states: IDLE, SHIFT, GAP.
- IDLE:
  - ready=1.
  - On a clk edge with start=1 and abort=0: latch the pattern (per use_default) and reps, go to SHIFT.
  - That same edge registers seq_out=pattern[SEQ_LEN-1] and seq_valid=1, so the first bit is visible in the cycle after start is sampled. Latency is 1 clk.
- SHIFT:
  - ready=0.
  - Each edge shifts the pattern left and drives the next bit; the bit index counts SEQ_LEN-1 down to 0.
  - A frame occupies exactly SEQ_LEN consecutive cycles of seq_valid=1.
  - frame_last=1 while bit index 0 is on seq_out.
  - After the last bit, if frames remain:
    - GAP_CYCLES>0: go to GAP.
    - GAP_CYCLES=0: reload the latched pattern and continue in SHIFT with no bubble, so consecutive frames abut (exercises detector overlap).
  - After the last bit with no frames remaining: go to IDLE.
  - done=1 coincides with frame_last of the final frame.
- GAP:
  - seq_out=IDLE_BIT, seq_valid=0 for exactly GAP_CYCLES cycles, then SHIFT with a fresh copy of the pattern.
- start while ready=0: ignored; the latched pattern and reps are unaffected by input changes mid-transfer.
- abort=1 in SHIFT or GAP:
  - Next edge: state=IDLE, seq_out=IDLE_BIT, seq_valid=0, frame_last=0, done=0; counters cleared.
- abort and start together in IDLE: abort wins; start is not accepted.
- Frame counter: 4-bit down-counter from reps; no wrap (reps=15 gives 16 frames, then stops).
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package seq_pkg holds:
  - SEQ_LEN_DEF=7 and SEQ_PATTERN_DEF=7'b1011010, shared with the detector so both ends agree.
  - State encoding constants for IDLE/SHIFT/GAP.
- One sub-module: seq_piso, a parameterised parallel-load, MSB-first shift register with load/shift/clear controls.
- The FSM and the counters stay in seq_gen_sr.

Test Plan:
- Reset then start=1 for 1 cycle, use_default=1, reps=0, GAP_CYCLES=0 -> seq_out = 1,0,1,1,0,1,0 on 7 consecutive cycles starting 1 clk after the start edge; seq_valid high for exactly those 7 cycles; done and frame_last high on the 7th; ready back to 1 next cycle; downstream detector flag=1 once.
- pattern_in=7'b1101001, use_default=0, reps=2, GAP_CYCLES=3 -> 3 frames of 1101001, each separated by 3 cycles of seq_out=0/seq_valid=0; 27 cycles total; frame_last pulses 3 times, done pulses once.
- use_default=1, reps=1, GAP_CYCLES=0 -> 14 contiguous bits 10110101011010; detector flags twice; no bubble between frames.
- start pulsed again at bit 3 of a frame with a different pattern_in -> ignored; original frame completes unchanged.
- abort at bit 4 of frame 1 (reps=3) -> next cycle seq_valid=0, seq_out=IDLE_BIT, ready=1, no done; a new start then sends a full frame normally.
- rst_n low for 5 ns mid-frame (asynchronous, off clock edge) -> outputs reach reset values immediately; detector sees no flag; a subsequent start sends a clean frame.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the serial sequence generator and its detector.
// Both ends import this so the pattern and width always agree.
package seq_pkg;

    localparam int SEQ_LEN_DEF = 7;
    localparam logic [SEQ_LEN_DEF-1:0] SEQ_PATTERN_DEF = 7'b1011010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register with clear/load/shift controls.
// Clear has priority over load, load over shift.
module seq_piso #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic         o_msb
);

    logic [W-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_d;
        end else if (i_shift) begin
            r_sr <= {r_sr[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[W-1];

endmodule

// File: rtl/seq_gen_sr.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, with
// repetitions and an optional idle gap between frames.
module seq_gen_sr
    import seq_pkg::*;
#(
    parameter int                 SEQ_LEN     = SEQ_LEN_DEF,
    parameter logic [SEQ_LEN-1:0] SEQ_DEFAULT = SEQ_LEN'(SEQ_PATTERN_DEF),
    parameter int                 GAP_CYCLES  = 0,
    parameter logic               IDLE_BIT    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               use_default,
    input  logic [SEQ_LEN-1:0] pattern_in,
    input  logic [3:0]         reps,
    input  logic               abort,
    output logic               ready,
    output logic               seq_out,
    output logic               seq_valid,
    output logic               frame_last,
    output logic               done
);

    localparam int IW = $clog2(SEQ_LEN);

    state_e             r_state, w_state;
    logic [IW-1:0]      r_idx, w_idx;
    logic [3:0]         r_frames, w_frames;
    logic [3:0]         r_gap, w_gap;
    logic [SEQ_LEN-1:0] r_pat, w_pat;
    logic               r_out, w_out;
    logic               r_valid, w_valid;
    logic               r_last, w_last;
    logic               r_done, w_done;
    logic               r_ready;

    logic               w_load, w_shift, w_clr;
    logic [SEQ_LEN-1:0] w_ld_val;
    logic [SEQ_LEN-1:0] w_sel_pat;
    logic               w_piso_msb;

    // The PISO holds the bits still to come; the bit on the wire is in r_out.
    seq_piso #(
        .W (SEQ_LEN)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (w_ld_val),
        .o_msb   (w_piso_msb)
    );

    assign w_sel_pat = use_default ? SEQ_DEFAULT : pattern_in;

    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_frames = r_frames;
        w_gap    = r_gap;
        w_pat    = r_pat;
        w_out    = IDLE_BIT;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        w_done   = 1'b0;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_clr    = 1'b0;
        w_ld_val = {r_pat[SEQ_LEN-2:0], 1'b0};

        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state  = ST_SHIFT;
                    w_pat    = w_sel_pat;
                    w_frames = reps;
                    w_idx    = IW'(SEQ_LEN-1);
                    w_load   = 1'b1;
                    w_ld_val = {w_sel_pat[SEQ_LEN-2:0], 1'b0};
                    w_out    = w_sel_pat[SEQ_LEN-1];
                    w_valid  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state  = ST_IDLE;
                    w_idx    = '0;
                    w_frames = '0;
                    w_gap    = '0;
                    w_clr    = 1'b1;
                end else if (r_idx != '0) begin
                    w_shift = 1'b1;
                    w_out   = w_piso_msb;
                    w_valid = 1'b1;
                    w_idx   = r_idx - 1'b1;
                    w_last  = (r_idx == IW'(1));
                    w_done  = w_last && (r_frames == '0);
                end else if (r_frames != '0) begin
                    w_frames = r_frames - 1'b1;
                    if (GAP_CYCLES != 0) begin
                        w_state = ST_GAP;
                        w_gap   = 4'(GAP_CYCLES-1);
                        w_clr   = 1'b1;
                    end else begin
                        // Abutting frames: reload with no bubble.
                        w_load  = 1'b1;
                        w_out   = r_pat[SEQ_LEN-1];
                        w_valid = 1'b1;
                        w_idx   = IW'(SEQ_LEN-1);
                    end
                end else begin
                    w_state = ST_IDLE;
                    w_clr   = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    w_state  = ST_IDLE;
                    w_idx    = '0;
                    w_frames = '0;
                    w_gap    = '0;
                    w_clr    = 1'b1;
                end else if (r_gap == '0) begin
                    w_state = ST_SHIFT;
                    w_load  = 1'b1;
                    w_out   = r_pat[SEQ_LEN-1];
                    w_valid = 1'b1;
                    w_idx   = IW'(SEQ_LEN-1);
                end else begin
                    w_gap = r_gap - 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_frames <= '0;
            r_gap    <= '0;
            r_pat    <= '0;
            r_out    <= IDLE_BIT;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_frames <= w_frames;
            r_gap    <= w_gap;
            r_pat    <= w_pat;
            r_out    <= w_out;
            r_valid  <= w_valid;
            r_last   <= w_last;
            r_done   <= w_done;
            r_ready  <= (w_state == ST_IDLE);
        end
    end

    assign ready      = r_ready;
    assign seq_out    = r_out;
    assign seq_valid  = r_valid;
    assign frame_last = r_last;
    assign done       = r_done;

endmodule

// File: tb/tb_seq_gen_sr.sv
// Scoreboard bench for seq_gen_sr: one instance without gap, one with a
// 3-cycle gap; expected bits carry the cycle they must appear in.
module tb_seq_gen_sr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start3;
    logic       use_default;
    logic [6:0] pattern_in;
    logic [3:0] reps;
    logic       abort;

    logic ready0, out0, valid0, last0, done0;
    logic ready3, out3, valid3, last3, done3;

    typedef struct {
        logic o;
        logic l;
        logic d;
        int   c;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    seq_gen_sr #(.GAP_CYCLES(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start0),
        .use_default (use_default),
        .pattern_in  (pattern_in),
        .reps        (reps),
        .abort       (abort),
        .ready       (ready0),
        .seq_out     (out0),
        .seq_valid   (valid0),
        .frame_last  (last0),
        .done        (done0)
    );

    seq_gen_sr #(.GAP_CYCLES(3)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start3),
        .use_default (use_default),
        .pattern_in  (pattern_in),
        .reps        (reps),
        .abort       (1'b0),
        .ready       (ready3),
        .seq_out     (out3),
        .seq_valid   (valid3),
        .frame_last  (last3),
        .done        (done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (valid0) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d0_stray_bit: got valid bit %0b expected none (cyc %0d)",
                         out0, cyc);
            end else begin
                e = q0.pop_front();
                chk("d0_bit", {29'd0, out0, last0, done0}, {29'd0, e.o, e.l, e.d});
                chk("d0_cycle", cyc, e.c);
            end
        end else begin
            chk("d0_idle", {29'd0, out0, last0, done0}, 32'd0);
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (valid3) begin
            if (q3.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d3_stray_bit: got valid bit %0b expected none (cyc %0d)",
                         out3, cyc);
            end else begin
                e = q3.pop_front();
                chk("d3_bit", {29'd0, out3, last3, done3}, {29'd0, e.o, e.l, e.d});
                chk("d3_cycle", cyc, e.c);
            end
        end else begin
            chk("d3_idle", {29'd0, out3, last3, done3}, 32'd0);
        end
    end

    // Called at a negedge; pushes expected bits (up to lim) and pulses start.
    task automatic issue(input bit sel, input logic [6:0] pat, input int nfr,
                         input int gap, input int lim);
        int   base;
        int   n;
        exp_t e;
        base = cyc + 1;
        n = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < 7; b++) begin
                if (n < lim) begin
                    e.o = pat[6-b];
                    e.l = (b == 6);
                    e.d = (b == 6) && (f == nfr - 1);
                    e.c = base + f * (7 + gap) + b;
                    if (sel) q3.push_back(e);
                    else q0.push_back(e);
                end
                n++;
            end
        end
        reps = 4'(nfr - 1);
        if (sel) start3 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic drain(input bit sel);
        int k;
        k = 0;
        while (((sel ? q3.size() : q0.size()) != 0) && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(sel ? "d3_drain_left" : "d0_drain_left",
            sel ? q3.size() : q0.size(), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start0      = 1'b0;
        start3      = 1'b0;
        use_default = 1'b0;
        pattern_in  = '0;
        reps        = '0;
        abort       = 1'b0;
        #12;
        chk("rst_ready0", {31'd0, ready0}, 1);
        chk("rst_ready3", {31'd0, ready3}, 1);
        chk("rst_out0", {28'd0, out0, valid0, last0, done0}, 0);
        chk("rst_out3", {28'd0, out3, valid3, last3, done3}, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Default pattern, single frame, no gap
        use_default = 1'b1;
        issue(0, 7'b1011010, 1, 0, 99);
        @(negedge clk);
        chk("t1_busy", {31'd0, ready0}, 0);
        drain(0);
        chk("t1_ready_last", {31'd0, ready0}, 0);
        @(negedge clk);
        chk("t1_ready_after", {31'd0, ready0}, 1);

        // Custom pattern, 3 frames with 3-cycle gaps
        use_default = 1'b0;
        pattern_in  = 7'b1101001;
        issue(1, 7'b1101001, 3, 3, 99);
        drain(1);
        @(negedge clk);
        chk("t2_ready_after", {31'd0, ready3}, 1);

        // Two abutting default frames
        use_default = 1'b1;
        issue(0, 7'b1011010, 2, 0, 99);
        drain(0);
        @(negedge clk);

        // Start while busy is ignored
        use_default = 1'b0;
        pattern_in  = 7'b1100101;
        issue(0, 7'b1100101, 1, 0, 99);
        repeat (3) @(negedge clk);
        pattern_in = 7'b0011110;
        reps       = 4'd5;
        start0     = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain(0);
        repeat (4) @(negedge clk);

        // Abort at bit 4 of frame 1, reps=3
        pattern_in = 7'b1101001;
        issue(0, 7'b1101001, 4, 0, 5);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("t5_abort_outs", {28'd0, out0, valid0, last0, done0}, 0);
        chk("t5_abort_ready", {31'd0, ready0}, 1);
        chk("t5_abort_left", q0.size(), 0);
        @(negedge clk);
        issue(0, 7'b1101001, 1, 0, 99);
        drain(0);
        @(negedge clk);

        // Abort together with start in idle: abort wins
        start0 = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort  = 1'b0;
        #1;
        chk("t5b_abort_start", {31'd0, ready0}, 1);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-frame
        use_default = 1'b1;
        issue(0, 7'b1011010, 1, 0, 3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {28'd0, out0, valid0, last0, done0}, 0);
        chk("t6_rst_ready", {31'd0, ready0}, 1);
        #4 rst_n = 1'b1;
        chk("t6_rst_left", q0.size(), 0);
        @(negedge clk);
        @(negedge clk);
        issue(0, 7'b1011010, 1, 0, 99);
        drain(0);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
